wrn_mqueue_multi_slot: RTL and testbench

- Parametrised successor to the single-slot host/CPU message queue used by node-core firmware tests.
- Holds g_num_slots independent circular queues, each with g_entries messages of g_msg_words words, in one shared synchronous RAM.
- Producer port (CPU side) does claim/write/commit; consumer port (host side) does random-access read/discard.
- Drives per-slot status and a masked, registered interrupt toward the host interrupt controller.

---
 rtl/mqueue_pkg.sv | 41 ++++
 rtl/mqueue_slot_ctrl.sv | 136 +++++++++++++
 rtl/wrn_mqueue_multi_slot.sv | 117 +++++++++++
 tb/tb_wrn_mqueue_multi_slot.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mqueue_pkg.sv
// ============================================================================
// Module      : mqueue_pkg
// Description : Shared types and width helpers for wrn_mqueue_multi_slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mqueue_pkg;

  localparam int c_ovf_w = 16;

  function automatic int f_log2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits for single-element ranges
  function automatic int f_idx_w(input int n);
    return (n > 1) ? f_log2_ceil(n) : 1;
  endfunction

  function automatic int f_cnt_w(input int entries);
    return f_log2_ceil(entries) + 1;
  endfunction

  function automatic int f_count_lsb(input int slot, input int cnt_w);
    return slot * cnt_w;
  endfunction

  typedef enum logic [0:0] {
    SLOT_IDLE    = 1'b0,
    SLOT_CLAIMED = 1'b1
  } slot_state_t;

endpackage

`default_nettype wire

// File: rtl/mqueue_slot_ctrl.sv
// ============================================================================
// Module      : mqueue_slot_ctrl
// Description : Pointers, occupancy and claim FSM for one queue slot.
//               Overflow counter present when MQUEUE_OVERFLOW_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mqueue_slot_ctrl
  import mqueue_pkg::*;
#(
  parameter int g_entries   = 8,
  parameter int g_msg_words = 32,
  localparam int c_ent_w    = f_idx_w(g_entries),
  localparam int c_word_w   = f_idx_w(g_msg_words),
  localparam int c_cnt_w    = f_cnt_w(g_entries)
) (
  input  logic                clk_sys_i,
  input  logic                rst_sys_i,
  input  logic                wr_sel_i,
  input  logic                wr_claim_i,
  input  logic                wr_valid_i,
  input  logic                wr_commit_i,
  input  logic                rd_discard_i,
  output logic                wr_en_o,
  output logic [c_ent_w-1:0]  wr_ptr_o,
  output logic [c_word_w-1:0] wr_word_o,
  output logic [c_ent_w-1:0]  rd_ptr_o,
  output logic [c_cnt_w-1:0]  count_o,
  output logic                full_o,
  output logic                empty_o,
`ifdef MQUEUE_OVERFLOW_CNT_EN
  input  logic                ovf_clr_i,
  output logic [c_ovf_w-1:0]  ovf_cnt_o,
`endif
  output logic                ready_o
);

  localparam logic [c_word_w-1:0] c_word_last = c_word_w'(g_msg_words - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_full  = c_cnt_w'(g_entries);

  slot_state_t         r_state;
  slot_state_t         w_state_nxt;
  logic [c_ent_w-1:0]  r_wr_ptr;
  logic [c_ent_w-1:0]  r_rd_ptr;
  logic [c_word_w-1:0] r_word;
  logic                r_word_done;
  logic [c_cnt_w-1:0]  r_count;
  logic                w_full;
  logic                w_claim_ok;
  logic                w_commit_ok;
  logic                w_wr_en;
  logic                w_pop;

  assign w_full = (r_count == c_cnt_full);
  assign w_pop  = rd_discard_i && (r_count != '0);

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) r_state <= SLOT_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLOT_IDLE:    if (w_claim_ok)  w_state_nxt = SLOT_CLAIMED;
      SLOT_CLAIMED: if (w_commit_ok) w_state_nxt = SLOT_IDLE;
      default:      w_state_nxt = SLOT_IDLE;
    endcase
  end

  // A same-cycle commit suppresses the claim, even in IDLE where the commit itself is a no-op
  always_comb begin
    w_claim_ok  = 1'b0;
    w_commit_ok = 1'b0;
    w_wr_en     = 1'b0;
    case (r_state)
      SLOT_IDLE: w_claim_ok = wr_sel_i && wr_claim_i && !wr_commit_i && !w_full;
      SLOT_CLAIMED: begin
        w_commit_ok = wr_sel_i && wr_commit_i;
        w_wr_en     = wr_sel_i && wr_valid_i && !r_word_done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_word      <= '0;
      r_word_done <= 1'b0;
      r_count     <= '0;
    end else begin
      if (w_claim_ok) begin
        r_word      <= '0;
        r_word_done <= 1'b0;
      end else if (w_wr_en) begin
        if (r_word == c_word_last) r_word_done <= 1'b1;
        else                       r_word      <= r_word + 1'b1;
      end
      if (w_commit_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)       r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_commit_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef MQUEUE_OVERFLOW_CNT_EN
  logic [c_ovf_w-1:0] r_ovf_cnt;

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i || ovf_clr_i)
      r_ovf_cnt <= '0;
    else if (wr_sel_i && wr_claim_i && w_full && (r_ovf_cnt != '1))
      r_ovf_cnt <= r_ovf_cnt + 1'b1;
  end

  assign ovf_cnt_o = r_ovf_cnt;
`endif

  assign wr_en_o   = w_wr_en;
  assign wr_ptr_o  = r_wr_ptr;
  assign wr_word_o = r_word;
  assign rd_ptr_o  = r_rd_ptr;
  assign count_o   = r_count;
  assign full_o    = w_full;
  assign empty_o   = (r_count == '0);
  assign ready_o   = !w_full && (r_state == SLOT_IDLE);

endmodule

`default_nettype wire

// File: rtl/wrn_mqueue_multi_slot.sv
// ============================================================================
// Module      : wrn_mqueue_multi_slot
// Description : Multi-slot host/CPU message queue over one shared RAM.
//               Optional overflow counters: define MQUEUE_OVERFLOW_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wrn_mqueue_multi_slot
  import mqueue_pkg::*;
#(
  parameter int g_num_slots  = 4,
  parameter int g_entries    = 8,
  parameter int g_msg_words  = 32,
  parameter int g_data_width = 32,
  localparam int c_slot_w    = f_idx_w(g_num_slots),
  localparam int c_word_w    = f_idx_w(g_msg_words),
  localparam int c_cnt_w     = f_cnt_w(g_entries)
) (
  input  logic                           clk_sys_i,
  input  logic                           rst_sys_i,
  input  logic [c_slot_w-1:0]            wr_slot_i,
  input  logic                           wr_claim_i,
  input  logic                           wr_valid_i,
  input  logic [g_data_width-1:0]        wr_data_i,
  input  logic                           wr_commit_i,
  output logic                           wr_ready_o,
  input  logic [c_slot_w-1:0]            rd_slot_i,
  input  logic [c_word_w-1:0]            rd_addr_i,
  output logic [g_data_width-1:0]        rd_data_o,
  input  logic                           rd_discard_i,
  output logic [g_num_slots-1:0]         full_o,
  output logic [g_num_slots-1:0]         empty_o,
  output logic [g_num_slots*c_cnt_w-1:0] count_o,
  input  logic [g_num_slots-1:0]         irq_mask_i,
`ifdef MQUEUE_OVERFLOW_CNT_EN
  output logic [g_num_slots*c_ovf_w-1:0] ovf_cnt_o,
  input  logic [g_num_slots-1:0]         ovf_clr_i,
`endif
  output logic                           irq_o
);

  localparam int c_ent_w  = f_idx_w(g_entries);
  localparam int c_addr_w = c_slot_w + c_ent_w + c_word_w;
  localparam int c_depth  = g_num_slots * g_entries * g_msg_words;

  logic [c_ent_w-1:0]      w_wr_ptr  [g_num_slots];
  logic [c_ent_w-1:0]      w_rd_ptr  [g_num_slots];
  logic [c_word_w-1:0]     w_wr_word [g_num_slots];
  logic [c_cnt_w-1:0]      w_count   [g_num_slots];
  logic [g_num_slots-1:0]  w_wr_en;
  logic [g_num_slots-1:0]  w_ready;
  logic [g_num_slots-1:0]  w_full;
  logic [g_num_slots-1:0]  w_empty;
  logic [c_addr_w-1:0]     w_wr_addr;
  logic [c_addr_w-1:0]     w_rd_addr;

  logic [g_data_width-1:0] r_ram [c_depth];
  logic [g_data_width-1:0] r_rd_data;
  logic                    r_irq;

  for (genvar i = 0; i < g_num_slots; i++) begin : g_slot
    mqueue_slot_ctrl #(
      .g_entries   (g_entries),
      .g_msg_words (g_msg_words)
    ) u_slot_ctrl (
      .clk_sys_i    (clk_sys_i),
      .rst_sys_i    (rst_sys_i),
      .wr_sel_i     (wr_slot_i == c_slot_w'(i)),
      .wr_claim_i   (wr_claim_i),
      .wr_valid_i   (wr_valid_i),
      .wr_commit_i  (wr_commit_i),
      .rd_discard_i (rd_discard_i && (rd_slot_i == c_slot_w'(i))),
      .wr_en_o      (w_wr_en[i]),
      .wr_ptr_o     (w_wr_ptr[i]),
      .wr_word_o    (w_wr_word[i]),
      .rd_ptr_o     (w_rd_ptr[i]),
      .count_o      (w_count[i]),
      .full_o       (w_full[i]),
      .empty_o      (w_empty[i]),
`ifdef MQUEUE_OVERFLOW_CNT_EN
      .ovf_clr_i    (ovf_clr_i[i]),
      .ovf_cnt_o    (ovf_cnt_o[i*c_ovf_w +: c_ovf_w]),
`endif
      .ready_o      (w_ready[i])
    );

    assign count_o[f_count_lsb(i, c_cnt_w) +: c_cnt_w] = w_count[i];
  end

  // Only the slot selected by wr_slot_i can raise its write enable
  assign w_wr_addr = {wr_slot_i, w_wr_ptr[wr_slot_i], w_wr_word[wr_slot_i]};
  assign w_rd_addr = {rd_slot_i, w_rd_ptr[rd_slot_i], rd_addr_i};

  always_ff @(posedge clk_sys_i) begin
    if (|w_wr_en) r_ram[w_wr_addr] <= wr_data_i;
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      r_rd_data <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_rd_data <= r_ram[w_rd_addr];
      r_irq     <= |(~w_empty & irq_mask_i);
    end
  end

  assign rd_data_o  = r_rd_data;
  assign irq_o      = r_irq;
  assign full_o     = w_full;
  assign empty_o    = w_empty;
  assign wr_ready_o = w_ready[wr_slot_i];

endmodule

`default_nettype wire

// File: tb/tb_wrn_mqueue_multi_slot.sv
// ============================================================================
// Module      : tb_wrn_mqueue_multi_slot
// Description : Directed self-checking bench for wrn_mqueue_multi_slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wrn_mqueue_multi_slot;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic [1:0]  wr_slot;
  logic        wr_claim;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_commit;
  logic        wr_ready;
  logic [1:0]  rd_slot;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_discard;
  logic [3:0]  full;
  logic [3:0]  empty;
  logic [15:0] count;
  logic [3:0]  irq_mask;
  logic        irq;
`ifdef MQUEUE_OVERFLOW_CNT_EN
  logic [63:0] ovf_cnt;
  logic [3:0]  ovf_clr;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_sys = ~clk_sys;

  wrn_mqueue_multi_slot dut (
    .clk_sys_i    (clk_sys),
    .rst_sys_i    (rst_sys),
    .wr_slot_i    (wr_slot),
    .wr_claim_i   (wr_claim),
    .wr_valid_i   (wr_valid),
    .wr_data_i    (wr_data),
    .wr_commit_i  (wr_commit),
    .wr_ready_o   (wr_ready),
    .rd_slot_i    (rd_slot),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .rd_discard_i (rd_discard),
    .full_o       (full),
    .empty_o      (empty),
    .count_o      (count),
    .irq_mask_i   (irq_mask),
`ifdef MQUEUE_OVERFLOW_CNT_EN
    .ovf_cnt_o    (ovf_cnt),
    .ovf_clr_i    (ovf_clr),
`endif
    .irq_o        (irq)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cnt(input int s);
    return count[s*4 +: 4];
  endfunction

  // One message: claim, write the given number of words starting at base, commit
  task automatic put_msg(input logic [1:0] s, input logic [31:0] base, input int words,
                         input logic with_discard);
    wr_slot  = s;
    wr_claim = 1'b1;
    tick();
    wr_claim = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < words; i++) begin
      wr_data = base + 32'(i);
      tick();
    end
    wr_valid   = 1'b0;
    wr_commit  = 1'b1;
    rd_discard = with_discard;
    tick();
    wr_commit  = 1'b0;
    rd_discard = 1'b0;
  endtask

  initial begin
    rst_sys = 1'b1; wr_slot = '0; wr_claim = 0; wr_valid = 0; wr_data = '0;
    wr_commit = 0; rd_slot = '0; rd_addr = '0; rd_discard = 0; irq_mask = '0;
`ifdef MQUEUE_OVERFLOW_CNT_EN
    ovf_clr = '0;
`endif
    tick(); tick();
    check("rst_empty", 32'(empty), 32'hF);
    check("rst_full", 32'(full), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_ready", 32'(wr_ready), 32'h1);
    check("rst_rd_data", rd_data, 32'h0);
    rst_sys = 1'b0;

    // Slot 0 basic message
    wr_slot = 2'd0; wr_claim = 1'b1; tick(); wr_claim = 1'b0;
    check("s0_claimed_ready", 32'(wr_ready), 32'h0);
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin wr_data = 32'hA0 + 32'(i); tick(); end
    wr_valid = 1'b0; wr_commit = 1'b1; tick(); wr_commit = 1'b0;
    check("s0_count", 32'(cnt(0)), 32'h1);
    check("s0_empty", 32'(empty[0]), 32'h0);
    check("s0_ready_after", 32'(wr_ready), 32'h1);
    rd_slot = 2'd0; rd_addr = 5'd2; tick();
    check("s0_rd_a2", rd_data, 32'hA2);

    // Interrupt masking: only slot 2 enabled
    irq_mask = 4'b0100;
    put_msg(2'd0, 32'hB0, 1, 1'b0);
    tick();
    check("irq_s0_masked", 32'(irq), 32'h0);
    put_msg(2'd2, 32'hC0, 1, 1'b0);
    check("irq_same_cycle", 32'(irq), 32'h0);
    tick();
    check("irq_assert", 32'(irq), 32'h1);
    rd_slot = 2'd2; rd_discard = 1'b1; tick(); rd_discard = 1'b0;
    check("irq_hold", 32'(irq), 32'h1);
    tick();
    check("irq_deassert", 32'(irq), 32'h0);
    irq_mask = 4'b0000;

    // Fill slot 1 and overflow it
    for (int k = 0; k < 8; k++) put_msg(2'd1, 32'h100 + 32'(k), 1, 1'b0);
    check("s1_count_full", 32'(cnt(1)), 32'h8);
    check("s1_full", 32'(full[1]), 32'h1);
    check("s1_ready_full", 32'(wr_ready), 32'h0);
    wr_claim = 1'b1; tick(); wr_claim = 1'b0;
    check("s1_ovf_count", 32'(cnt(1)), 32'h8);
    wr_commit = 1'b1; tick(); wr_commit = 1'b0;
    check("s1_commit_ignored", 32'(cnt(1)), 32'h8);
`ifdef MQUEUE_OVERFLOW_CNT_EN
    check("s1_ovf_cnt", 32'(ovf_cnt[31:16]), 32'h1);
`endif
    rd_slot = 2'd1; rd_addr = 5'd0; tick();
    check("s1_head", rd_data, 32'h100);

    // Slot 2: concurrent commit/discard and pointer wrap
    for (int k = 0; k < 3; k++) put_msg(2'd2, 32'h200 + 32'(k), 1, 1'b0);
    check("s2_count3", 32'(cnt(2)), 32'h3);
    rd_slot = 2'd2; rd_addr = 5'd0;
    put_msg(2'd2, 32'h203, 1, 1'b1);
    check("s2_old_head", rd_data, 32'h200);
    check("s2_count_cd", 32'(cnt(2)), 32'h3);
    tick();
    check("s2_new_head", rd_data, 32'h201);
    for (int j = 0; j < 16; j++) begin
      put_msg(2'd2, 32'h204 + 32'(j), 1, 1'b1);
      tick();
      check("s2_wrap_head", rd_data, 32'h202 + 32'(j));
      check("s2_wrap_count", 32'(cnt(2)), 32'h3);
    end

    // Slot 3: over-long message is truncated
    put_msg(2'd3, 32'h300, 40, 1'b0);
    check("s3_count", 32'(cnt(3)), 32'h1);
    rd_slot = 2'd3; rd_addr = 5'd31; tick();
    check("s3_word31", rd_data, 32'h31F);
    rd_addr = 5'd0; tick();
    check("s3_word0", rd_data, 32'h300);

    // Reset during a claim on slot 0
    check("s0_count2", 32'(cnt(0)), 32'h2);
    wr_slot = 2'd0; wr_claim = 1'b1; tick(); wr_claim = 1'b0;
    wr_valid = 1'b1; wr_data = 32'hD0; tick(); wr_valid = 1'b0;
    rst_sys = 1'b1; tick(); rst_sys = 1'b0;
    check("mid_rst_count", 32'(count), 32'h0);
    check("mid_rst_empty", 32'(empty), 32'hF);
    check("mid_rst_full", 32'(full), 32'h0);
    check("mid_rst_ready", 32'(wr_ready), 32'h1);
    wr_claim = 1'b1; tick(); wr_claim = 1'b0;
    check("post_rst_claim", 32'(wr_ready), 32'h0);
    wr_commit = 1'b1; tick(); wr_commit = 1'b0;
    check("post_rst_count", 32'(cnt(0)), 32'h1);
    rd_slot = 2'd0; rd_addr = 5'd2; tick();
    check("post_rst_stale", rd_data, 32'hA2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
